uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares one UART transmitter between PORTS AXI-stream byte sources.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant held per packet (or per beat), one IDLE cycle per rearbitration.
// Latency: request -> grant 1 cycle -> output beat 1 cycle later; source ready drops while the output register is stalled.
module uart_tx_arbiter #(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter bit LOCK_ON_TLAST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
);

    localparam int PW = $clog2(PORTS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PORTS-1:0]        r_grant;
    logic [PORTS-1:0]        w_grant_nxt;
    logic [PW-1:0]           r_gidx;
    logic [PW-1:0]           w_gidx_nxt;
    logic [PW-1:0]           r_ptr;
    logic [PW-1:0]           w_ptr_nxt;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic                    r_last;
    logic                    r_vld;

    logic                    w_pick_vld;
    logic [PW-1:0]           w_pick_idx;
    logic                    w_out_free;
    logic                    w_xfer;
    logic                    w_release;
    logic [DATA_WIDTH-1:0]   w_sel_dat;
    logic                    w_sel_last;

    // Scan from the pointer downwards in offset so the smallest offset wins last.
    always_comb begin
        logic [PW:0] w_sum;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_sum      = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(PORTS)) begin
                w_sum = w_sum - (PW+1)'(PORTS);
            end
            if (s_axis_tvalid[w_sum[PW-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_sum[PW-1:0];
            end
        end
    end

    assign w_out_free    = !r_vld || m_axis_tready;
    assign s_axis_tready = ((r_state == ST_GRANT) && w_out_free) ? r_grant : '0;
    assign w_sel_dat     = s_axis_tdata[r_gidx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_last    = s_axis_tlast[r_gidx];
    assign w_xfer        = |(s_axis_tvalid & s_axis_tready);
    assign w_release     = w_xfer && (!LOCK_ON_TLAST || w_sel_last);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = PORTS'(1) << w_pick_idx;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_gidx == PW'(PORTS - 1)) ? '0 : r_gidx + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Output stage only loads when empty or draining, so a stalled beat never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_last <= 1'b0;
        end else if (w_xfer) begin
            r_vld  <= 1'b1;
            r_dat  <= w_sel_dat;
            r_last <= w_sel_last;
        end else if (m_axis_tready) begin
            r_vld  <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_dat;
    assign m_axis_tvalid = r_vld;
    assign m_axis_tlast  = r_last;
    assign grant         = r_grant;
    assign busy          = (r_state == ST_GRANT) || r_vld;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tlast;
    logic                  m_tready;

    logic [PORTS-1:0]      a_s_tready, b_s_tready, a_grant, b_grant;
    logic [DW-1:0]         a_m_tdata, b_m_tdata;
    logic                  a_m_tvalid, b_m_tvalid, a_m_tlast, b_m_tlast, a_busy, b_busy;

    logic                  use_nl;
    logic [PORTS-1:0]      s_rdy, grant;
    logic [DW-1:0]         m_dat;
    logic                  m_vld, m_last, busy;

    assign s_rdy  = use_nl ? b_s_tready : a_s_tready;
    assign grant  = use_nl ? b_grant    : a_grant;
    assign m_dat  = use_nl ? b_m_tdata  : a_m_tdata;
    assign m_vld  = use_nl ? b_m_tvalid : a_m_tvalid;
    assign m_last = use_nl ? b_m_tlast  : a_m_tlast;
    assign busy   = use_nl ? b_busy     : a_busy;

    uart_tx_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .LOCK_ON_TLAST(1'b1)) dut_lock (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(a_s_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
        .m_axis_tready(m_tready),
        .grant(a_grant), .busy(a_busy)
    );

    uart_tx_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .LOCK_ON_TLAST(1'b0)) dut_beat (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
        .m_axis_tready(m_tready),
        .grant(b_grant), .busy(b_busy)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [8:0]  src_q [PORTS][$];
    bit          started [PORTS];
    logic [8:0]  exp_q [$];
    logic [8:0]  obs [$];
    bit          gap_en;
    bit          rdy_rand;
    int          rdy_hold;
    bit          prev_stall;
    logic [8:0]  prev_beat;

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            src_q[i].delete();
            started[i] = 1'b0;
        end
        exp_q.delete();
        obs.delete();
        prev_stall = 1'b0;
        rdy_hold   = 0;
        gap_en     = 1'b0;
        rdy_rand   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Packet-level model: next owner is the first non-empty source from the pointer.
    task automatic build_exp(input bit lock);
        logic [8:0] mq [PORTS][$];
        logic [8:0] b;
        int ptr;
        int g;
        ptr = 0;
        for (int i = 0; i < PORTS; i++) mq[i] = src_q[i];
        exp_q.delete();
        for (int guard = 0; guard < 1000; guard++) begin
            g = -1;
            for (int k = 0; k < PORTS; k++) begin
                int p;
                p = (ptr + k) % PORTS;
                if (g < 0 && mq[p].size() > 0) g = p;
            end
            if (g < 0) break;
            do begin
                b = mq[g].pop_front();
                exp_q.push_back(b);
            end while (lock && !b[8] && mq[g].size() > 0);
            ptr = (g + 1) % PORTS;
        end
    endtask

    task automatic tick();
        logic [8:0] h;
        logic [8:0] e;
        @(negedge clk);
        if (rdy_hold > 0) begin
            m_tready = 1'b0;
            rdy_hold--;
        end else begin
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        for (int i = 0; i < PORTS; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                s_tdata[i*DW +: DW] = h[7:0];
                s_tlast[i]  = h[8];
                s_tvalid[i] = !(gap_en && started[i]) || ($urandom_range(0, 3) != 0);
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        #1;
        if (prev_stall) begin
            n_cmp++;
            if (!m_vld || {m_last, m_dat} !== prev_beat) begin
                n_fail++;
                $display("FAIL hold_stable: got vld=%0b beat=%h need vld=1 beat=%h", m_vld, {m_last, m_dat}, prev_beat);
            end
        end
        n_cmp++;
        if ((s_rdy & ~grant) != 0 || $countones(s_rdy) > 1 || (m_vld && !m_tready && s_rdy != 0)) begin
            n_fail++;
            $display("FAIL ready_rule: got s_tready=%b grant=%b m_vld=%0b m_rdy=%0b need one-hot within grant, 0 when stalled",
                     s_rdy, grant, m_vld, m_tready);
        end
        n_cmp++;
        if (busy !== ((grant != 0) || m_vld)) begin
            n_fail++;
            $display("FAIL busy: got %0b need %0b", busy, (grant != 0) || m_vld);
        end
        for (int i = 0; i < PORTS; i++) begin
            if (s_tvalid[i] && s_rdy[i]) begin
                h = src_q[i].pop_front();
                started[i] = !h[8];
            end
        end
        if (m_vld && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_extra: got beat %h need no beat", {m_last, m_dat});
            end else begin
                e = exp_q.pop_front();
                if ({m_last, m_dat} !== e) begin
                    n_fail++;
                    $display("FAIL out_beat: got %h need %h", {m_last, m_dat}, e);
                end
            end
            obs.push_back({m_last, m_dat});
        end
        prev_stall = m_vld && !m_tready;
        prev_beat  = {m_last, m_dat};
        @(posedge clk);
    endtask

    task automatic drain(input int budget);
        int c;
        int left;
        c = 0;
        left = 1;
        while (left != 0 && c < budget) begin
            tick();
            c++;
            left = exp_q.size() + (m_vld ? 1 : 0);
            for (int i = 0; i < PORTS; i++) left += src_q[i].size();
        end
        n_cmp++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d items outstanding after %0d cycles need 0", left, budget);
        end
    endtask

    task automatic wait_obs(input int n);
        int c;
        c = 0;
        while (obs.size() < n && c < 100) begin
            tick();
            c++;
        end
        n_cmp++;
        if (obs.size() < n) begin
            n_fail++;
            $display("FAIL wait_obs: got %0d beats need %0d", obs.size(), n);
        end
    endtask

    task automatic test_reset();
        use_nl   = 1'b0;
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (a_grant !== '0 || b_grant !== '0) begin
            n_fail++;
            $display("FAIL reset_grant: got %b/%b need 0", a_grant, b_grant);
        end
        n_cmp++;
        if (m_vld !== 1'b0 || m_dat !== '0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got vld=%0b dat=%h last=%0b need 0", m_vld, m_dat, m_last);
        end
        n_cmp++;
        if (busy !== 1'b0 || s_rdy !== '0) begin
            n_fail++;
            $display("FAIL reset_busy_rdy: got busy=%0b rdy=%b need 0", busy, s_rdy);
        end
    endtask

    task automatic test_single();
        do_reset();
        use_nl = 1'b0;
        @(posedge clk); #1;
        s_tdata[2*DW +: DW] = 8'hA5;
        s_tlast[2]  = 1'b1;
        s_tvalid[2] = 1'b1;
        m_tready    = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (grant !== 4'b0100 || s_rdy !== 4'b0100 || m_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1: got grant=%b rdy=%b vld=%0b need 0100 0100 0", grant, s_rdy, m_vld);
        end
        @(posedge clk); #1;
        s_tvalid = '0;
        s_tlast  = '0;
        n_cmp++;
        if (m_vld !== 1'b1 || m_dat !== 8'hA5 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_c2: got vld=%0b dat=%h last=%0b need 1 a5 1", m_vld, m_dat, m_last);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (grant !== '0 || m_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c3: got grant=%b vld=%0b busy=%0b need 0 0 0", grant, m_vld, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] rr_ref [5];
        rr_ref = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        use_nl = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < PORTS; i++) src_q[i].push_back({1'b1, 8'(16 + i)});
        build_exp(1'b1);
        drain(200);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= obs.size() || obs[k][7:0] !== rr_ref[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %h need %h", k, (k < obs.size()) ? obs[k][7:0] : 8'hxx, rr_ref[k]);
            end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        use_nl = 1'b0;
        src_q[0].push_back(9'h001);
        src_q[0].push_back(9'h002);
        src_q[0].push_back(9'h103);
        src_q[1].push_back(9'h121);
        build_exp(1'b1);
        drain(200);
        n_cmp++;
        if (obs.size() != 4 || obs[0] !== 9'h001 || obs[1] !== 9'h002 || obs[2] !== 9'h103 || obs[3] !== 9'h121) begin
            n_fail++;
            $display("FAIL lock_order: got %0d beats first=%h need 001,002,103,121", obs.size(),
                     (obs.size() > 0) ? obs[0] : 9'h0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        use_nl = 1'b0;
        src_q[0].push_back(9'h031);
        src_q[0].push_back(9'h032);
        src_q[0].push_back(9'h033);
        src_q[0].push_back(9'h134);
        src_q[3].push_back(9'h13f);
        build_exp(1'b1);
        wait_obs(2);
        rdy_hold = 20;
        drain(300);
        n_cmp++;
        if (obs.size() != 5 || obs[4] !== 9'h13f) begin
            n_fail++;
            $display("FAIL bp_tail: got %0d beats need 5 ending 13f", obs.size());
        end
    endtask

    task automatic test_no_lock();
        do_reset();
        use_nl = 1'b1;
        src_q[0].push_back(9'h0a0);
        src_q[0].push_back(9'h1a1);
        src_q[1].push_back(9'h0b0);
        src_q[1].push_back(9'h1b1);
        build_exp(1'b0);
        drain(200);
        n_cmp++;
        if (obs.size() != 4 || obs[0] !== 9'h0a0 || obs[1] !== 9'h0b0 || obs[2] !== 9'h1a1 || obs[3] !== 9'h1b1) begin
            n_fail++;
            $display("FAIL nolock_order: got %0d beats need 0a0,0b0,1a1,1b1", obs.size());
        end
        use_nl = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        use_nl = 1'b0;
        src_q[0].push_back(9'h0c0);
        src_q[0].push_back(9'h0c1);
        src_q[0].push_back(9'h1c2);
        src_q[1].push_back(9'h1d0);
        build_exp(1'b1);
        wait_obs(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_grant !== '0 || a_m_tvalid !== 1'b0 || a_busy !== 1'b0 || a_s_tready !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got grant=%b vld=%0b busy=%0b rdy=%b need 0", a_grant, a_m_tvalid, a_busy, a_s_tready);
        end
        do_reset();
        src_q[1].push_back(9'h1e1);
        src_q[0].push_back(9'h1e0);
        build_exp(1'b1);
        drain(100);
        n_cmp++;
        if (obs.size() < 1 || obs[0] !== 9'h1e0) begin
            n_fail++;
            $display("FAIL reset_ptr: got first=%h need 1e0", (obs.size() > 0) ? obs[0] : 9'h0);
        end
    endtask

    task automatic test_random();
        int npk;
        int len;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            use_nl   = it[0];
            gap_en   = !it[0];
            rdy_rand = 1'b1;
            for (int i = 0; i < PORTS; i++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        src_q[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
                end
            end
            build_exp(!it[0]);
            drain(3000);
        end
        use_nl = 1'b0;
    endtask

    initial begin
        use_nl = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_no_lock();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
